// File: rtl/vga_sync_monitor.sv
// VGA sync timing monitor.
// Measures line length, hsync width and lines per frame on a pixel-rate enable.
// The monitor locks after LOCK_FRAMES consecutive clean frames and drops lock on
// any timing error. Errors are accumulated in sticky flags.
// Optional feature: define VGA_MON_CRC_EN to compute a CRC-16-CCITT over the
// active-window colour bytes of each frame. Without it, frame_crc is tied to 0.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC_W    = 96,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT       = 480
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic        pix_ce,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic [2:0]  vga_r,
  input  logic [2:0]  vga_g,
  input  logic [1:0]  vga_b,
  input  logic        err_clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [2:0]  err_flags,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [15:0] frame_cnt,
  output logic [1:0]  mon_state,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } state_e;

  localparam logic [10:0] HMax        = 11'h7FF;
  localparam logic [9:0]  VMax        = 10'h3FF;
  localparam logic [11:0] HTotal      = 12'(H_TOTAL);
  localparam logic [10:0] HSyncW      = 11'(H_SYNC_W);
  localparam logic [9:0]  VTotal      = 10'(V_TOTAL);
  localparam logic [3:0]  LockFrames  = 4'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic        hs_q, vs_q;
  logic [10:0] h_cnt_q;
  logic [10:0] hs_w_q;
  logic [9:0]  v_cnt_q;
  logic [10:0] line_len_q;
  logic [9:0]  frame_lines_q;
  logic [15:0] frame_cnt_q;
  logic [2:0]  err_flags_q, err_flags_d;
  logic        err_pulse_q;
  logic        skip_q, skip_d;
  logic [3:0]  good_q, good_d;
  logic        ferr_q, ferr_d;

  logic        hs_fall, hs_rise, vs_fall;
  logic [11:0] h_len;
  logic [9:0]  v_inc;
  logic        line_err, width_err, frame_err;
  logic [2:0]  err_vec;
  logic        err_any, monitoring;

  // Edge detection and per-event error terms.
  always_comb begin
    hs_fall    = pix_ce & hs_q & ~vga_h_sync;
    hs_rise    = pix_ce & ~hs_q & vga_h_sync;
    vs_fall    = pix_ce & vs_q & ~vga_v_sync;
    h_len      = {1'b0, h_cnt_q} + 12'd1;
    // A coincident hs_fall is counted before the frame length is judged.
    v_inc      = (hs_fall && (v_cnt_q != VMax)) ? v_cnt_q + 10'd1 : v_cnt_q;
    // Saturation is flagged only on the step into 2047, so once per run-away.
    line_err   = (hs_fall & ~skip_q & (h_len != HTotal)) |
                 (pix_ce & ~hs_fall & (h_cnt_q == HMax - 11'd1));
    width_err  = hs_rise & (hs_w_q != HSyncW);
    frame_err  = vs_fall & (v_inc != VTotal);
    err_vec    = {frame_err, width_err, line_err};
    err_any    = |err_vec;
    monitoring = (state_q == StMeasure) || (state_q == StLocked);
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_comb begin
    err_flags_d = (err_clr ? 3'b000 : err_flags_q) | (monitoring ? err_vec : 3'b000);
  end

  // The first line after leaving SEARCH is partial, so its length is not judged.
  always_comb begin
    skip_d = skip_q;
    if (!monitoring) begin
      skip_d = 1'b1;
    end else if (hs_fall) begin
      skip_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StSearch;
      good_q  <= 4'd0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      ferr_q  <= ferr_d;
    end
  end

  // FSM next-state: count clean frames in MEASURE, drop lock on any error.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    ferr_d  = ferr_q | (monitoring & err_any);
    case (state_q)
      StMeasure: begin
        if (vs_fall) begin
          ferr_d = 1'b0;
          if (ferr_q || err_any) begin
            good_d = 4'd0;
          end else begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 >= LockFrames) begin
              state_d = StLocked;
            end
          end
        end
      end
      StLocked: begin
        if (err_any) begin
          state_d = StSearch;
        end
      end
      default: begin
        if (vs_fall) begin
          state_d = StMeasure;
          good_d  = 4'd0;
          ferr_d  = 1'b0;
        end
      end
    endcase
  end

  // FSM outputs; the unused encoding reads as SEARCH.
  always_comb begin
    locked    = 1'b0;
    mon_state = 2'd0;
    case (state_q)
      StMeasure: mon_state = 2'd1;
      StLocked: begin
        mon_state = 2'd2;
        locked    = 1'b1;
      end
      default: mon_state = 2'd0;
    endcase
  end

  // Sync sampling, counters and measurement registers.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_cnt_q       <= 11'd0;
      hs_w_q        <= 11'd0;
      v_cnt_q       <= 10'd0;
      line_len_q    <= 11'd0;
      frame_lines_q <= 10'd0;
      frame_cnt_q   <= 16'd0;
      err_flags_q   <= 3'b000;
      err_pulse_q   <= 1'b0;
      skip_q        <= 1'b1;
    end else begin
      if (pix_ce) begin
        hs_q <= vga_h_sync;
        vs_q <= vga_v_sync;
        if (hs_fall) begin
          h_cnt_q    <= 11'd0;
          line_len_q <= h_len[10:0];
        end else if (h_cnt_q != HMax) begin
          h_cnt_q <= h_cnt_q + 11'd1;
        end
        if (!vga_h_sync) begin
          if (hs_fall) begin
            hs_w_q <= 11'd1;
          end else if (hs_w_q != HMax) begin
            hs_w_q <= hs_w_q + 11'd1;
          end
        end
        if (vs_fall) begin
          frame_lines_q <= v_inc;
          v_cnt_q       <= 10'd0;
        end else begin
          v_cnt_q <= v_inc;
        end
      end
      if ((state_q == StLocked) && vs_fall) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      err_flags_q <= err_flags_d;
      err_pulse_q <= (state_q == StLocked) & err_any;
      skip_q      <= skip_d;
    end
  end

  assign err_pulse   = err_pulse_q;
  assign err_flags   = err_flags_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_q, crc_next, frame_crc_q;
  logic [7:0]  pix_byte;
  logic        in_win;

  // CRC-16-CCITT, MSB first, over the colour byte of each active pixel.
  always_comb begin
    pix_byte = {vga_r, vga_g, vga_b};
    in_win   = ({21'd0, h_cnt_q} >= H_ACT_START) &&
               ({21'd0, h_cnt_q} <  H_ACT_START + H_ACT) &&
               ({22'd0, v_cnt_q} >= V_ACT_START) &&
               ({22'd0, v_cnt_q} <  V_ACT_START + V_ACT);
    crc_next = crc_q;
    for (int i = 7; i >= 0; i--) begin
      crc_next = {crc_next[14:0], 1'b0} ^
                 ({16{crc_next[15] ^ pix_byte[i]}} & 16'h1021);
    end
  end

  // Accumulate over the frame, publish and restart on vs_fall.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
    end else if (vs_fall) begin
      frame_crc_q <= crc_q;
      crc_q       <= 16'hFFFF;
    end else if (pix_ce && in_win) begin
      crc_q <= crc_next;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  logic        unused_colour;
  logic [31:0] unused_win;
  assign unused_colour = ^{vga_r, vga_g, vga_b};
  assign unused_win    = H_ACT_START ^ H_ACT ^ V_ACT_START ^ V_ACT;
  assign frame_crc     = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a shrunken 40x12 raster
// (hsync 6 ticks, vsync low on lines 0-1, pix_ce every 4th clock).
module tb_vga_sync_monitor;

  localparam int HT  = 40;
  localparam int HSW = 6;
  localparam int VT  = 12;

  logic        board_clk;
  logic        Reset;
  logic        pix_ce;
  logic        vga_h_sync, vga_v_sync;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic        err_clr;
  logic        locked, err_pulse;
  logic [2:0]  err_flags;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [15:0] frame_cnt;
  logic [1:0]  mon_state;
  logic [15:0] frame_crc;

  int checks = 0;
  int errors = 0;
  int gy = 0;
  int pulse_cnt = 0;
  int p0;

  vga_sync_monitor #(
    .H_TOTAL    (HT),
    .H_SYNC_W   (HSW),
    .V_TOTAL    (VT),
    .LOCK_FRAMES(2),
    .H_ACT_START(8),
    .H_ACT      (24),
    .V_ACT_START(2),
    .V_ACT      (8)
  ) dut (
    .board_clk  (board_clk),
    .Reset      (Reset),
    .pix_ce     (pix_ce),
    .vga_h_sync (vga_h_sync),
    .vga_v_sync (vga_v_sync),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_flags  (err_flags),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .frame_cnt  (frame_cnt),
    .mon_state  (mon_state),
    .frame_crc  (frame_crc)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  // Count clock cycles with err_pulse high.
  always @(negedge board_clk) begin
    if (err_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic hs, input logic vs);
    @(negedge board_clk);
    vga_h_sync = hs;
    vga_v_sync = vs;
    pix_ce     = 1'b1;
    @(negedge board_clk);
    pix_ce = 1'b0;
    repeat (2) @(negedge board_clk);
  endtask

  task automatic do_line(input int len, input int sw);
    for (int x = 0; x < len; x++) begin
      tick((x < sw) ? 1'b0 : 1'b1, (gy < 2) ? 1'b0 : 1'b1);
    end
    gy = (gy + 1) % VT;
  endtask

  task automatic do_lines(input int n);
    for (int i = 0; i < n; i++) do_line(HT, HSW);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge board_clk);
    err_clr = 1'b1;
    @(negedge board_clk);
    err_clr = 1'b0;
  endtask

  function automatic logic [15:0] crc_model(input int nbytes);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'hFFFF;
    d = 8'hFF;
    for (int n = 0; n < nbytes; n++) begin
      for (int i = 7; i >= 0; i--) begin
        if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
        else              c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] crc_exp();
`ifdef VGA_MON_CRC_EN
    return crc_model(24 * 8);
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    Reset      = 1'b1;
    pix_ce     = 1'b0;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    vga_r      = 3'h7;
    vga_g      = 3'h7;
    vga_b      = 2'h3;
    err_clr    = 1'b0;
    repeat (3) @(negedge board_clk);
    chk("rst_state",  32'(mon_state),   32'd0);
    chk("rst_locked", 32'(locked),      32'd0);
    chk("rst_flags",  32'(err_flags),   32'd0);
    chk("rst_linelen", 32'(line_len),   32'd0);
    chk("rst_fcnt",   32'(frame_cnt),   32'd0);
    @(negedge board_clk);
    Reset = 1'b0;

    // Nominal: first vs_fall enters MEASURE, lock at the start of frame 3.
    do_lines(2 * VT);
    chk("pre_lock", 32'(locked), 32'd0);
    do_lines(3);
    chk("nom_locked",  32'(locked),      32'd1);
    chk("nom_state",   32'(mon_state),   32'd2);
    chk("nom_linelen", 32'(line_len),    32'd40);
    chk("nom_flines",  32'(frame_lines), 32'd12);
    chk("nom_flags",   32'(err_flags),   32'd0);
    chk("nom_fcnt0",   32'(frame_cnt),   32'd0);
    chk("nom_crc",     32'(frame_crc),   32'(crc_exp()));
    do_lines(VT - 3 + 1);
    chk("nom_fcnt1",   32'(frame_cnt),   32'd1);

    // Short line while locked.
    do_lines(3);
    p0 = pulse_cnt;
    do_line(HT - 1, HSW);
    do_lines(1);
    chk("short_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("short_state", 32'(mon_state),      32'd0);
    chk("short_flags", 32'(err_flags),      32'd1);
    chk("short_fcnt",  32'(frame_cnt),      32'd1);
    pulse_clr();
    chk("short_clr",   32'(err_flags),      32'd0);
    do_lines(6);
    do_lines(2 * VT + 1);
    chk("relock1", 32'(locked), 32'd1);

    // Narrow hsync while locked.
    do_lines(2);
    p0 = pulse_cnt;
    do_line(HT, HSW - 1);
    chk("width_flags",  32'(err_flags),      32'd2);
    chk("width_locked", 32'(locked),         32'd0);
    chk("width_pulse",  32'(pulse_cnt - p0), 32'd1);
    pulse_clr();
    chk("width_clr",    32'(err_flags),      32'd0);
    do_lines(8);
    do_lines(2 * VT + 1);
    chk("relock2", 32'(locked), 32'd1);

    // hsync stuck high: h_cnt sits at 39 and steps into 2047 on idle tick 2008.
    do_lines(2);
    p0 = pulse_cnt;
    idle(2007);
    chk("sat_before_lock",  32'(locked),         32'd1);
    chk("sat_before_pulse", 32'(pulse_cnt - p0), 32'd0);
    idle(1);
    chk("sat_state",  32'(mon_state),      32'd0);
    chk("sat_pulse",  32'(pulse_cnt - p0), 32'd1);
    chk("sat_flags",  32'(err_flags),      32'd1);
    idle(992);
    chk("sat_single", 32'(pulse_cnt - p0), 32'd1);
    gy = 0;
    pulse_clr();
    do_lines(2 * VT + 1);
    chk("relock3", 32'(locked), 32'd1);

    // Reset mid-frame.
    do_lines(5);
    chk("prerst_fcnt",   32'(frame_cnt),   32'd1);
    chk("prerst_flines", 32'(frame_lines), 32'd12);
    @(negedge board_clk);
    Reset = 1'b1;
    #1;
    chk("mrst_locked",  32'(locked),      32'd0);
    chk("mrst_state",   32'(mon_state),   32'd0);
    chk("mrst_pulse",   32'(err_pulse),   32'd0);
    chk("mrst_flags",   32'(err_flags),   32'd0);
    chk("mrst_linelen", 32'(line_len),    32'd0);
    chk("mrst_flines",  32'(frame_lines), 32'd0);
    chk("mrst_fcnt",    32'(frame_cnt),   32'd0);
    chk("mrst_crc",     32'(frame_crc),   32'd0);
    @(negedge board_clk);
    Reset = 1'b0;
    do_lines(6);
    do_lines(VT + 1);
    chk("mrst_one_frame", 32'(locked), 32'd0);
    do_lines(VT);
    chk("mrst_relock",  32'(locked),      32'd1);
    chk("mrst_flines2", 32'(frame_lines), 32'd12);
    chk("mrst_linelen2", 32'(line_len),   32'd40);
    chk("mrst_flags2",  32'(err_flags),   32'd0);
    chk("mrst_crc2",    32'(frame_crc),   32'(crc_exp()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
